// File: rtl/bitbakery_frame_tx.sv
`default_nettype none
// ------------------------------------------------------------------------
// bitbakery_frame_tx : framed UART transmitter (START, payload, [checksum], END)
// Checksum byte enabled by defining BITBAKERY_FRAME_TX_CHECKSUM_EN.  Rev 1.0
// ------------------------------------------------------------------------
module bitbakery_frame_tx #(
  parameter int         N_BYTES      = 131,
  parameter int         CLKS_PER_BIT = 434,
  parameter int         PARITY_MODE  = 1,
  parameter logic [7:0] START_BYTE   = 8'hFF,
  parameter logic [7:0] END_BYTE     = 8'hFE
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 iniciar,
  input  logic [N_BYTES*8-1:0] payload,
  output logic                 saida_serial,
  output logic                 ocupado,
  output logic                 pronto,
  output logic [7:0]           byte_idx,
  output logic [3:0]           db_estado
);

  localparam int                TICK_W       = $clog2(CLKS_PER_BIT);
  localparam logic [TICK_W-1:0] TICK_LAST    = TICK_W'(CLKS_PER_BIT - 1);
  localparam logic [8:0]        PAYLOAD_LAST = 9'(N_BYTES);
`ifdef BITBAKERY_FRAME_TX_CHECKSUM_EN
  localparam logic [8:0]        LAST_IDX     = 9'(N_BYTES + 2);
`else
  localparam logic [8:0]        LAST_IDX     = 9'(N_BYTES + 1);
`endif

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_START = 4'd1,
    S_DATA  = 4'd2,
    S_PAR   = 4'd3,
    S_STOP  = 4'd4,
    S_NEXT  = 4'd5,
    S_DONE  = 4'd6
  } state_t;

  state_t               state;
  state_t               state_nx;
  logic [TICK_W-1:0]    tick;
  logic [2:0]           bit_cnt;
  logic [8:0]           byte_cnt;
  logic [N_BYTES*8-1:0] shadow;
  logic [7:0]           cur_byte;
  logic                 tick_wrap;
  logic                 par_bit;
  logic                 accept;
  logic                 byte_end;

`ifdef BITBAKERY_FRAME_TX_CHECKSUM_EN
  logic [7:0] csum;
  logic [7:0] csum_in;

  always_comb begin
    csum_in = '0;
    for (int k = 0; k < N_BYTES; k++) begin
      csum_in = csum_in ^ payload[8*k +: 8];
    end
  end
`endif

  assign tick_wrap = (tick == TICK_LAST);
  assign accept    = (state == S_IDLE) && iniciar;
  assign byte_end  = (state == S_STOP) && tick_wrap;
  assign byte_idx  = byte_cnt[7:0];
  assign db_estado = state;

  // Payload bytes are consumed from the bottom of the shifting snapshot.
  always_comb begin
    cur_byte = END_BYTE;
    if (byte_cnt == 9'd0) begin
      cur_byte = START_BYTE;
    end else if (byte_cnt <= PAYLOAD_LAST) begin
      cur_byte = shadow[7:0];
`ifdef BITBAKERY_FRAME_TX_CHECKSUM_EN
    end else if (byte_cnt == PAYLOAD_LAST + 9'd1) begin
      cur_byte = csum;
`endif
    end
  end

  assign par_bit = (PARITY_MODE == 2) ? ~^cur_byte : ^cur_byte;

  always_comb begin
    state_nx     = state;
    saida_serial = 1'b1;
    ocupado      = 1'b0;
    pronto       = 1'b0;
    case (state)
      S_IDLE: begin
        if (iniciar) state_nx = S_START;
      end
      S_START: begin
        saida_serial = 1'b0;
        ocupado      = 1'b1;
        if (tick_wrap) state_nx = S_DATA;
      end
      S_DATA: begin
        saida_serial = cur_byte[bit_cnt];
        ocupado      = 1'b1;
        if (tick_wrap && (bit_cnt == 3'd7)) begin
          state_nx = (PARITY_MODE == 0) ? S_STOP : S_PAR;
        end
      end
      S_PAR: begin
        saida_serial = par_bit;
        ocupado      = 1'b1;
        if (tick_wrap) state_nx = S_STOP;
      end
      // The NEXT decision is folded into the last stop-bit cycle so bytes abut.
      S_STOP: begin
        ocupado = 1'b1;
        if (tick_wrap) state_nx = (byte_cnt == LAST_IDX) ? S_DONE : S_START;
      end
      S_DONE: begin
        pronto   = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= S_IDLE;
      tick     <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      shadow   <= '0;
`ifdef BITBAKERY_FRAME_TX_CHECKSUM_EN
      csum     <= '0;
`endif
    end else begin
      state <= state_nx;

      if ((state == S_IDLE) || (state == S_DONE) || tick_wrap) begin
        tick <= '0;
      end else begin
        tick <= tick + 1'b1;
      end

      if (state != S_DATA) begin
        bit_cnt <= '0;
      end else if (tick_wrap) begin
        bit_cnt <= bit_cnt + 3'd1;
      end

      if (accept) begin
        byte_cnt <= '0;
        shadow   <= payload;
`ifdef BITBAKERY_FRAME_TX_CHECKSUM_EN
        csum     <= csum_in;
`endif
      end else if (byte_end && (byte_cnt != LAST_IDX)) begin
        byte_cnt <= byte_cnt + 9'd1;
        if (byte_cnt != 9'd0) shadow <= shadow >> 8;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bitbakery_frame_tx.sv
`default_nettype none
// tb_bitbakery_frame_tx : scoreboard bench; none/even/odd parity variants run side by side,
// each with a serial decoder that consumes the shared expected-byte queue.
module tb_bitbakery_frame_tx;

  localparam int CPB = 4;
`ifdef BITBAKERY_FRAME_TX_CHECKSUM_EN
  localparam int FRAME_BYTES = 6;
`else
  localparam int FRAME_BYTES = 5;
`endif
  localparam int FRAME_MAIN = FRAME_BYTES * 11 * CPB;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iniciar;
  logic [23:0] payload;
  logic        line    [3];
  logic        busy_o  [3];
  logic        pr      [3];
  logic [7:0]  bidx    [3];
  logic [3:0]  st      [3];

  logic [15:0] exp_q[$];   // {byte_idx, byte}
  int checks = 0;
  int passes = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act === expv) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, expv);
  endtask

  for (genvar gi = 0; gi < 3; gi++) begin : g_inst
    localparam int NBITS = (gi == 0) ? 10 : 11;

    bitbakery_frame_tx #(
      .N_BYTES(3), .CLKS_PER_BIT(CPB), .PARITY_MODE(gi),
      .START_BYTE(8'hFF), .END_BYTE(8'hFE)
    ) u_dut (
      .clock(clk), .reset(rst_n), .iniciar(iniciar), .payload(payload),
      .saida_serial(line[gi]), .ocupado(busy_o[gi]), .pronto(pr[gi]),
      .byte_idx(bidx[gi]), .db_estado(st[gi])
    );

    int          cnt     = 0;
    int          rd_i    = 0;
    int          pr_cnt  = 0;
    bit          active  = 0;
    bit          prev_pr = 0;
    logic [10:0] sh      = '0;
    logic [15:0] ent;
    logic        expar;

    always @(negedge clk) begin
      if (rst_n !== 1'b1) begin
        active  = 0;
        prev_pr = 0;
        rd_i    = exp_q.size();
      end else begin
        if (pr[gi] === 1'b1) begin
          check("pronto_single_pulse", prev_pr, 0);
          pr_cnt++;
        end
        prev_pr = pr[gi];
        if (!active) begin
          if (line[gi] === 1'b0) begin
            active = 1;
            cnt    = 0;
          end
        end else begin
          cnt++;
          if (cnt % CPB == CPB / 2) begin
            sh[cnt / CPB] = line[gi];
            if (cnt / CPB == NBITS - 1) begin
              active = 0;
              if (rd_i < exp_q.size()) begin
                ent   = exp_q[rd_i];
                rd_i++;
                expar = (gi == 2) ? ~^ent[7:0] : ((gi == 1) ? ^ent[7:0] : 1'b0);
                check("byte", {bidx[gi], sh[NBITS-1], (gi == 0) ? 1'b0 : sh[9], sh[8:1]},
                      {ent[15:8], 1'b1, expar, ent[7:0]});
              end else begin
                check("extra_byte", rd_i + 1, exp_q.size());
              end
            end
          end
        end
      end
    end
  end

  task automatic push_frame(input logic [23:0] pl, input logic [7:0] csum);
    exp_q.push_back({8'd0, 8'hFF});
    for (int k = 0; k < 3; k++) exp_q.push_back({8'(k + 1), pl[8*k +: 8]});
`ifdef BITBAKERY_FRAME_TX_CHECKSUM_EN
    exp_q.push_back({8'd4, csum});
    exp_q.push_back({8'd5, 8'hFE});
`else
    if (csum == 8'h00) exp_q.push_back({8'd4, 8'hFE});
    else exp_q.push_back({8'd4, 8'hFE});
`endif
  endtask

  task automatic start_frame(input logic [23:0] pl, output int t0);
    @(negedge clk);
    payload = pl;
    iniciar = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    check("accept_ocupado", busy_o[1], 1);
    check("accept_state", st[1], 1);
    check("accept_idx", bidx[1], 0);
  endtask

  task automatic wait_pronto(input int t0, output int n);
    int guard;
    guard = 0;
    while (pr[1] !== 1'b1 && guard < 3000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    n = cyc - t0;
  endtask

  int t0, t1, n, guard;

  initial begin
    rst_n   = 1'b0;
    iniciar = 1'b1;
    payload = '0;

    // reset held with iniciar asserted
    repeat (3) begin
      @(posedge clk);
      #1;
      check("rst_line", line[1], 1);
      check("rst_ocupado", busy_o[1], 0);
      check("rst_pronto", pr[1], 0);
      check("rst_state", st[1], 0);
    end
    check("rst_idx", bidx[1], 0);
    #1;
    rst_n   = 1'b1;
    iniciar = 1'b0;
    repeat (2) @(posedge clk);

    // single frame, payload 0A0501
    push_frame(24'h0A0501, 8'h0E);
    start_frame(24'h0A0501, t0);
    @(negedge clk);
    iniciar = 1'b0;
    wait_pronto(t0, n);
    check("frame_len", n, FRAME_MAIN);
    check("done_ocupado", busy_o[1], 0);
    @(posedge clk);
    #1;
    check("pronto_width", pr[1], 0);
    check("idle_after_done", st[1], 0);
    repeat (4) @(posedge clk);

    // reset during DATA of byte 2 aborts the frame
    push_frame(24'h0A0501, 8'h0E);
    start_frame(24'h0A0501, t0);
    @(negedge clk);
    iniciar = 1'b0;
    guard = 0;
    while (!(bidx[1] == 8'd2 && st[1] == 4'd2) && guard < 1000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("abort_reach_data", {bidx[1], st[1]}, {8'd2, 4'd2});
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("abort_line", line[1], 1);
    check("abort_pronto", pr[1], 0);
    check("abort_ocupado", busy_o[1], 0);
    check("abort_state", st[1], 0);
    #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    push_frame(24'h55AA00, 8'hFF);
    start_frame(24'h55AA00, t0);
    @(negedge clk);
    iniciar = 1'b0;
    wait_pronto(t0, n);
    check("fresh_frame_len", n, FRAME_MAIN);
    repeat (4) @(posedge clk);

    // iniciar held high, payload changed mid-frame
    push_frame(24'h123456, 8'h70);
    push_frame(24'h3C817E, 8'hC3);
    start_frame(24'h123456, t0);
    repeat (20) @(negedge clk);
    payload = 24'h3C817E;
    wait_pronto(t0, n);
    check("b2b_frame1_len", n, FRAME_MAIN);
    @(posedge clk);
    #1;
    check("b2b_gap_idle", {busy_o[1], st[1]}, {1'b0, 4'd0});
    @(posedge clk);
    #1;
    t1 = cyc;
    check("b2b_restart", {busy_o[1], st[1]}, {1'b1, 4'd1});
    while (cyc - t0 < 300) @(posedge clk);
    @(negedge clk);
    iniciar = 1'b0;
    @(posedge clk);
    #1;
    wait_pronto(t1, n);
    check("b2b_frame2_len", n, FRAME_MAIN);
    guard = 0;
    while ((busy_o[0] || busy_o[1] || busy_o[2]) && guard < 1000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("all_idle", {busy_o[0], busy_o[1], busy_o[2]}, 0);
    repeat (10) @(posedge clk);

    check("bytes_seen_none", g_inst[0].rd_i, exp_q.size());
    check("bytes_seen_even", g_inst[1].rd_i, exp_q.size());
    check("bytes_seen_odd", g_inst[2].rd_i, exp_q.size());
    check("pronto_count_none", g_inst[0].pr_cnt, 4);
    check("pronto_count_even", g_inst[1].pr_cnt, 4);
    check("pronto_count_odd", g_inst[2].pr_cnt, 4);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation timeout");
  end

endmodule
`default_nettype wire
